sipo_ctrl: RTL and testbench
============================

SIPO_CTRL -- requirements
Module: sipo_ctrl

Interface
REQ-001 Parameter AES_DATA_WIDTH, 128, payload bit count for opcodes 0 and 2.
REQ-002 Parameter KEY_DATA_WIDTH, 128, payload bit count for opcode 3.
REQ-003 Parameter MEM_DATA_WIDTH, 32, payload bit count for opcode 1.
REQ-004 Parameter CNT_WIDTH, 8, width of the completed-frame counter.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 ser_valid_i  input  1  ser_bit_i carries a bit this cycle.
REQ-008 ser_bit_i  input  1  serial stream from PC link.
REQ-009 abort_i  input  1  drop current frame, return to IDLE.
REQ-010 sipo_en_o  output  1  shift enable to deserializer.
REQ-011 sipo_send_o  output  1  capture strobe, asserted with last payload bit.
REQ-012 sipo_instr_o  output  2  decoded opcode to deserializer.
REQ-013 sipo_data_o  output  1  payload bit to deserializer.
REQ-014 busy_o  output  1  frame in progress (state not IDLE).
REQ-015 done_o  output  1  one-cycle pulse, cycle after sipo_send_o.
REQ-016 frame_cnt_o  output  CNT_WIDTH  completed frames, wraps.

Function
REQ-017 Frame format SHALL be: start bit '1', opcode bit 0, opcode bit 1, then N payload bits, LSB first; only cycles with ser_valid_i=1 consume a bit.
REQ-018 N SHALL be AES_DATA_WIDTH for opcode 0/2, MEM_DATA_WIDTH for opcode 1, KEY_DATA_WIDTH for opcode 3.
REQ-019 FSM states SHALL be IDLE, OP0, OP1, PAYLOAD, DONE.
REQ-020 IDLE: valid bit '1' -> OP0; valid bit '0' ignored, stay IDLE.
REQ-021 OP0: valid bit latched as opcode[0] -> OP1; OP1: valid bit latched as opcode[1], bit counter loaded with N-1 -> PAYLOAD.
REQ-022 PAYLOAD: each valid bit SHALL drive sipo_en_o=1, sipo_data_o=ser_bit_i combinationally in the same cycle, and decrement the counter.
REQ-023 sipo_send_o SHALL be 1 exactly in the PAYLOAD cycle consuming bit N-1 (counter=0), together with sipo_en_o=1; then -> DONE.
REQ-024 DONE: done_o=1 for one cycle, frame_cnt_o increments modulo 2^CNT_WIDTH, -> IDLE; ser_valid_i in DONE SHALL be ignored.
REQ-025 sipo_en_o and sipo_send_o SHALL be 0 in any cycle with ser_valid_i=0 or state not PAYLOAD; gaps stall the frame indefinitely.
REQ-026 sipo_instr_o SHALL hold the latched opcode from OP1 exit until the next frame's OP1 exit.
REQ-027 abort_i SHALL take priority over all inputs: next state IDLE, no send, no done, counter unchanged; in an abort cycle sipo_en_o and sipo_send_o SHALL be 0.
REQ-028 Bit counter SHALL be sized clog2 of max(N).

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, opcode 0, bit counter 0, frame_cnt_o 0, done_o 0; sipo_en_o, sipo_send_o, sipo_data_o, busy_o read 0.
REQ-030 Reset mid-frame SHALL discard the frame without asserting sipo_send_o; first frame after release is parsed from its start bit.

Structure
REQ-031 Opcode encodings (0 scan, 1 mem, 2 mem-to-aes, 3 key) and state encoding SHALL live in a shared PMU package used by both this block and the deserializer.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 Opcode 3, payload 0x000102030405060708090A0B0C0D0E0F, continuous valid -> exactly 128 sipo_en_o cycles, send on 128th, done next cycle, frame_cnt_o 1.
REQ-034 Opcode 1, payload 0xDEADBEEF with ser_valid_i low every third cycle -> 32 en cycles, send only on a valid cycle, sipo_instr_o=1.
REQ-035 Leading '0' bits x5 in IDLE then frame opcode 0 -> zeros ignored, frame parsed normally, busy_o rises on start bit.
REQ-036 abort_i at payload bit 60 of opcode 2 -> no send, no done, IDLE next, frame_cnt_o unchanged; following opcode 2 frame completes.
REQ-037 rst pulsed low at payload bit 10 -> all outputs 0 immediately, no send; 256 back-to-back frames -> frame_cnt_o wraps to 0.

Source files
------------

// File: rtl/pmu_pkg.sv
// rtl/pmu_pkg.sv - shared PMU opcode and frame-parser state encodings
package pmu_pkg;

    typedef enum logic [1:0] {
        OPC_SCAN    = 2'd0,
        OPC_MEM     = 2'd1,
        OPC_MEM2AES = 2'd2,
        OPC_KEY     = 2'd3
    } pmu_opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OP0     = 3'd1,
        ST_OP1     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DONE    = 3'd4
    } pmu_state_e;

endpackage

// File: rtl/sipo_ctrl.sv
// rtl/sipo_ctrl.sv - serial frame parser driving the PMU deserializer
module sipo_ctrl
    import pmu_pkg::*;
#(
    parameter int AES_DATA_WIDTH = 128,
    parameter int KEY_DATA_WIDTH = 128,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ser_valid_i,
    input  logic                 ser_bit_i,
    input  logic                 abort_i,
    output logic                 sipo_en_o,
    output logic                 sipo_send_o,
    output logic [1:0]           sipo_instr_o,
    output logic                 sipo_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] frame_cnt_o
);

    localparam int MAX_AK = (AES_DATA_WIDTH > KEY_DATA_WIDTH) ? AES_DATA_WIDTH : KEY_DATA_WIDTH;
    localparam int MAX_N  = (MAX_AK > MEM_DATA_WIDTH) ? MAX_AK : MEM_DATA_WIDTH;
    localparam int BCW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    pmu_state_e           state, state_nxt;
    logic                 op0_q;
    logic [1:0]           instr_q;
    logic [BCW-1:0]       bit_cnt;
    logic [CNT_WIDTH-1:0] frame_cnt;

    function automatic logic [BCW-1:0] payload_last(input logic [1:0] op);
        case (op)
            OPC_MEM: payload_last = BCW'(MEM_DATA_WIDTH - 1);
            OPC_KEY: payload_last = BCW'(KEY_DATA_WIDTH - 1);
            default: payload_last = BCW'(AES_DATA_WIDTH - 1);
        endcase
    endfunction

    always_comb begin
        state_nxt   = state;
        sipo_en_o   = 1'b0;
        sipo_send_o = 1'b0;
        done_o      = 1'b0;
        if (abort_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (ser_valid_i && ser_bit_i) state_nxt = ST_OP0;
                ST_OP0:     if (ser_valid_i) state_nxt = ST_OP1;
                ST_OP1:     if (ser_valid_i) state_nxt = ST_PAYLOAD;
                ST_PAYLOAD: begin
                    if (ser_valid_i) begin
                        sipo_en_o = 1'b1;
                        if (bit_cnt == '0) begin
                            sipo_send_o = 1'b1;
                            state_nxt   = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_o    = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Payload bit is gated so the deserializer sees 0 whenever it is not shifting.
    assign sipo_data_o  = sipo_en_o & ser_bit_i;
    assign busy_o       = (state != ST_IDLE);
    assign sipo_instr_o = instr_q;
    assign frame_cnt_o  = frame_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            op0_q     <= 1'b0;
            instr_q   <= 2'b00;
            bit_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!abort_i) begin
                case (state)
                    ST_OP0: if (ser_valid_i) op0_q <= ser_bit_i;
                    ST_OP1: begin
                        if (ser_valid_i) begin
                            instr_q <= {ser_bit_i, op0_q};
                            bit_cnt <= payload_last({ser_bit_i, op0_q});
                        end
                    end
                    ST_PAYLOAD: if (ser_valid_i && bit_cnt != '0) bit_cnt <= bit_cnt - BCW'(1);
                    ST_DONE:    frame_cnt <= frame_cnt + CNT_WIDTH'(1);
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_ctrl.sv
// tb/tb_sipo_ctrl.sv - directed self-checking bench for sipo_ctrl
module tb_sipo_ctrl;

    logic       clk, rst, ser_valid_i, ser_bit_i, abort_i;
    logic       sipo_en_o, sipo_send_o, sipo_data_o, busy_o, done_o;
    logic [1:0] sipo_instr_o;
    logic [7:0] frame_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] cap;
    int en_cnt, send_cnt, send_idx, done_cnt, bad_strobe;
    logic last_busy, busy_start, busy_op0;

    sipo_ctrl dut (
        .clk(clk), .rst(rst), .ser_valid_i(ser_valid_i), .ser_bit_i(ser_bit_i),
        .abort_i(abort_i), .sipo_en_o(sipo_en_o), .sipo_send_o(sipo_send_o),
        .sipo_instr_o(sipo_instr_o), .sipo_data_o(sipo_data_o), .busy_o(busy_o),
        .done_o(done_o), .frame_cnt_o(frame_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cap = '0; en_cnt = 0; send_cnt = 0; send_idx = -1; done_cnt = 0; bad_strobe = 0;
    endtask

    // Drive one cycle at the falling edge, observe the combinational outputs 1 ns later.
    task automatic step(input logic v, input logic b, input logic ab);
        @(negedge clk);
        ser_valid_i = v; ser_bit_i = b; abort_i = ab;
        #1;
        last_busy = busy_o;
        if ((sipo_en_o || sipo_send_o) && (!v || ab)) bad_strobe++;
        if (sipo_en_o) begin
            if (en_cnt < 128) cap[en_cnt] = sipo_data_o;
            en_cnt++;
        end
        if (sipo_send_o) begin
            send_cnt++;
            send_idx = en_cnt;
            if (!sipo_en_o) bad_strobe++;
        end
        if (done_o) done_cnt++;
    endtask

    task automatic frame(input logic [1:0] op, input logic [127:0] pl, input int n,
                         input bit gap, input int stop_at);
        int c;
        logic b;
        c = 0;
        for (int i = 0; i < n + 3; i++) begin
            if (stop_at >= 0 && i - 3 == stop_at) return;
            if (i == 0)      b = 1'b1;
            else if (i == 1) b = op[0];
            else if (i == 2) b = op[1];
            else             b = pl[i-3];
            if (gap && (c % 3 == 2)) begin
                step(1'b0, 1'b1, 1'b0);
                c++;
            end
            step(1'b1, b, 1'b0);
            c++;
            if (i == 0) busy_start = last_busy;
            if (i == 1) busy_op0 = last_busy;
        end
    endtask

    initial begin
        logic [127:0] pl_key, pl_mem, pl_aes, pl_aes2;
        pl_key  = 128'h000102030405060708090A0B0C0D0E0F;
        pl_mem  = 128'h000000000000000000000000DEADBEEF;
        pl_aes  = 128'hC3A5_5A3C_0F1E_2D3C_4B5A_6978_8796_A5B4;
        pl_aes2 = 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210;

        rst = 1'b0; ser_valid_i = 1'b1; ser_bit_i = 1'b1; abort_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_en", sipo_en_o, 0);
        chk("rst_send", sipo_send_o, 0);
        chk("rst_data", sipo_data_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", frame_cnt_o, 0);
        chk("rst_instr", sipo_instr_o, 0);
        ser_valid_i = 1'b0; ser_bit_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Opcode 3 key frame, continuous valid
        clr();
        frame(2'd3, pl_key, 128, 1'b0, -1);
        chk("key_en_cnt", en_cnt, 128);
        chk("key_send_cnt", send_cnt, 1);
        chk("key_send_idx", send_idx, 128);
        chk("key_data", cap, pl_key);
        chk("key_instr", sipo_instr_o, 3);
        chk("key_no_early_done", done_cnt, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("key_done", done_o, 1);
        chk("key_done_no_en", en_cnt, 128);
        step(1'b0, 1'b0, 1'b0);
        chk("key_idle_after", busy_o, 0);
        chk("key_done_pulse", done_cnt, 1);
        chk("key_frame_cnt", frame_cnt_o, 1);

        // Opcode 1 mem frame with valid low every third cycle
        clr();
        frame(2'd1, pl_mem, 32, 1'b1, -1);
        chk("mem_en_cnt", en_cnt, 32);
        chk("mem_send_cnt", send_cnt, 1);
        chk("mem_send_idx", send_idx, 32);
        chk("mem_strobe_gated", bad_strobe, 0);
        chk("mem_data", cap[31:0], 32'hDEADBEEF);
        chk("mem_instr", sipo_instr_o, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("mem_done", done_o, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("mem_frame_cnt", frame_cnt_o, 2);

        // Leading zeros ignored in IDLE, then opcode 0 frame
        clr();
        repeat (5) step(1'b1, 1'b0, 1'b0);
        chk("zeros_idle", last_busy, 0);
        frame(2'd0, pl_aes, 128, 1'b0, -1);
        chk("scan_busy_start", busy_start, 0);
        chk("scan_busy_op0", busy_op0, 1);
        chk("scan_en_cnt", en_cnt, 128);
        chk("scan_data", cap, pl_aes);
        chk("scan_instr", sipo_instr_o, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("scan_done_cnt", done_cnt, 1);
        chk("scan_frame_cnt", frame_cnt_o, 3);

        // Abort at payload bit 60 of opcode 2, then a clean opcode 2 frame
        clr();
        frame(2'd2, pl_aes, 128, 1'b0, 60);
        step(1'b1, pl_aes[60], 1'b1);
        chk("abort_en_gated", en_cnt, 60);
        chk("abort_strobe", bad_strobe, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_idle", busy_o, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_no_send", send_cnt, 0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_frame_cnt", frame_cnt_o, 3);
        clr();
        frame(2'd2, pl_aes2, 128, 1'b0, -1);
        chk("m2a_data", cap, pl_aes2);
        chk("m2a_instr", sipo_instr_o, 2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("m2a_send_cnt", send_cnt, 1);
        chk("m2a_frame_cnt", frame_cnt_o, 4);

        // Reset mid-frame at payload bit 10
        clr();
        frame(2'd1, pl_mem, 32, 1'b0, 10);
        @(negedge clk);
        rst = 1'b0; ser_valid_i = 1'b1; ser_bit_i = 1'b1; abort_i = 1'b0;
        #1;
        chk("mrst_en", sipo_en_o, 0);
        chk("mrst_send", sipo_send_o, 0);
        chk("mrst_data", sipo_data_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_cnt", frame_cnt_o, 0);
        chk("mrst_instr", sipo_instr_o, 0);
        @(negedge clk);
        rst = 1'b1; ser_valid_i = 1'b0;
        chk("mrst_no_send", send_cnt, 0);

        // 256 back-to-back frames wrap the frame counter
        clr();
        frame(2'd1, pl_mem, 32, 1'b0, -1);
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_frame", cap[31:0], 32'hDEADBEEF);
        step(1'b0, 1'b0, 1'b0);
        chk("post_rst_cnt", frame_cnt_o, 1);
        for (int k = 1; k < 256; k++) begin
            frame(2'd1, pl_mem, 32, 1'b0, -1);
            step(1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_sends", send_cnt, 256);
        chk("wrap_dones", done_cnt, 256);
        chk("wrap_cnt", frame_cnt_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
